// File: rtl/move_link_ctrl.sv
// Move exchange sequencer for the Connect-4 board link: owns the turn, serializes the
// local move, deserializes and checks the remote move, and flags a silent opponent.
module move_link_ctrl #(
  parameter int BIT_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int COL_MAX        = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_link_up,
  input  logic       i_first_player,
  input  logic       i_move_valid,
  input  logic [2:0] i_move_col,
  output logic       o_move_ready,
  output logic       o_tx_data,
  input  logic       i_rx_data,
  output logic       o_rx_move_valid,
  output logic [2:0] o_rx_move_col,
  output logic       o_my_turn,
  output logic       o_frame_err,
  output logic       o_timeout_err
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST    = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_HALF    = CW'(BIT_CYCLES / 2);
  localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    COL_LIMIT = 3'(COL_MAX);
  localparam logic [2:0]    LAST_BIT  = 3'd5;

  typedef enum logic [2:0] {
    S_OFFLINE = 3'd0,
    S_LOCAL   = 3'd1,
    S_TX      = 3'd2,
    S_REMOTE  = 3'd3,
    S_RX      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  function automatic logic col_parity(input logic [2:0] col);
    return col[2] ^ col[1] ^ col[0];
  endfunction

  state_t          r_state;
  state_t          w_state_fsm;
  state_t          w_state_nxt;
  logic            r_rx_meta;
  logic            r_rxs;
  logic            r_rxs_d;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_bit;
  logic [TW-1:0]   r_tmo;
  logic [4:0]      r_tx_frame;
  logic [3:0]      r_rx_shift;
  logic            r_tx_data;
  logic            r_rx_move_valid;
  logic [2:0]      r_rx_move_col;
  logic            r_frame_err;
  logic            r_timeout_err;

  logic            w_drop;
  logic            w_move_ok;
  logic            w_rx_edge;
  logic            w_bit_end;
  logic            w_sample;
  logic            w_false_start;
  logic            w_frame_done;
  logic            w_frame_ok;
  logic            w_timeout;
  logic [2:0]      w_rx_col;

  assign w_drop        = (r_state != S_OFFLINE) && !i_link_up;
  assign w_move_ok     = i_move_valid && (i_move_col <= COL_LIMIT);
  assign w_rx_edge     = r_rxs && !r_rxs_d;
  assign w_bit_end     = (r_cyc == C_LAST);
  assign w_sample      = (r_cyc == C_HALF);
  assign w_false_start = w_sample && (r_bit == 3'd0) && !r_rxs;
  assign w_frame_done  = w_sample && (r_bit == LAST_BIT);
  assign w_rx_col      = r_rx_shift[3:1];
  // At the stop-bit sample r_rxs is the stop bit itself.
  assign w_frame_ok    = (col_parity(w_rx_col) == r_rx_shift[0]) && !r_rxs &&
                         (w_rx_col <= COL_LIMIT);
  assign w_timeout     = (r_tmo == T_LIMIT);
  assign w_state_nxt   = w_drop ? S_OFFLINE : w_state_fsm;

  assign o_tx_data       = r_tx_data;
  assign o_rx_move_valid = r_rx_move_valid;
  assign o_rx_move_col   = r_rx_move_col;
  assign o_frame_err     = r_frame_err;
  assign o_timeout_err   = r_timeout_err;

  // Next-state and state-decoded outputs (link loss override applied above).
  always_comb begin
    w_state_fsm  = r_state;
    o_move_ready = 1'b0;
    o_my_turn    = 1'b0;
    case (r_state)
      S_OFFLINE: begin
        o_my_turn = i_first_player;
        if (i_link_up) begin
          w_state_fsm = i_first_player ? S_LOCAL : S_REMOTE;
        end else begin
          w_state_fsm = S_OFFLINE;
        end
      end
      S_LOCAL: begin
        o_move_ready = 1'b1;
        o_my_turn    = 1'b1;
        if (w_move_ok) begin
          w_state_fsm = S_TX;
        end else begin
          w_state_fsm = S_LOCAL;
        end
      end
      S_TX: begin
        o_my_turn = 1'b1;
        if (w_bit_end && (r_bit == LAST_BIT)) begin
          w_state_fsm = S_REMOTE;
        end else begin
          w_state_fsm = S_TX;
        end
      end
      S_REMOTE: begin
        // A start edge beats a coincident timeout.
        if (w_rx_edge) begin
          w_state_fsm = S_RX;
        end else if (w_timeout) begin
          w_state_fsm = S_HALT;
        end else begin
          w_state_fsm = S_REMOTE;
        end
      end
      S_RX: begin
        if (w_false_start) begin
          w_state_fsm = S_REMOTE;
        end else if (w_frame_done) begin
          w_state_fsm = w_frame_ok ? S_LOCAL : S_REMOTE;
        end else begin
          w_state_fsm = S_RX;
        end
      end
      S_HALT: begin
        w_state_fsm = S_HALT;
      end
      default: begin
        w_state_fsm = S_OFFLINE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_OFFLINE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Two-stage synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b0;
      r_rxs     <= 1'b0;
      r_rxs_d   <= 1'b0;
    end else begin
      r_rx_meta <= i_rx_data;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  // Silence counter: zero outside REMOTE_TURN, saturates at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo <= {TW{1'b0}};
    end else if (r_state != S_REMOTE) begin
      r_tmo <= {TW{1'b0}};
    end else if (!w_timeout) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  // Serializer, deserializer and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc           <= {CW{1'b0}};
      r_bit           <= 3'd0;
      r_tx_frame      <= 5'd0;
      r_rx_shift      <= 4'd0;
      r_tx_data       <= 1'b0;
      r_rx_move_valid <= 1'b0;
      r_rx_move_col   <= 3'd0;
      r_frame_err     <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_rx_move_valid <= 1'b0;
      r_frame_err     <= 1'b0;
      if (w_drop) begin
        r_tx_data <= 1'b0;
      end else begin
        case (r_state)
          S_OFFLINE: begin
            r_tx_data <= 1'b0;
            if (i_link_up) begin
              r_timeout_err <= 1'b0;
            end
          end
          S_LOCAL: begin
            if (w_move_ok) begin
              r_tx_frame <= {i_move_col, col_parity(i_move_col), 1'b0};
              r_tx_data  <= 1'b1;
              r_cyc      <= {CW{1'b0}};
              r_bit      <= 3'd0;
            end
          end
          S_TX: begin
            if (w_bit_end) begin
              r_cyc <= {CW{1'b0}};
              r_bit <= r_bit + 3'd1;
              if (r_bit == LAST_BIT) begin
                r_tx_data <= 1'b0;
              end else begin
                r_tx_data  <= r_tx_frame[4];
                r_tx_frame <= {r_tx_frame[3:0], 1'b0};
              end
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
          end
          S_REMOTE: begin
            // The edge cycle is count 0, so RX starts at count 1.
            if (w_rx_edge) begin
              r_cyc <= CW'(1);
              r_bit <= 3'd0;
            end else if (w_timeout) begin
              r_timeout_err <= 1'b1;
            end
          end
          S_RX: begin
            if (w_bit_end) begin
              r_cyc <= {CW{1'b0}};
              r_bit <= r_bit + 3'd1;
            end else begin
              r_cyc <= r_cyc + CW'(1);
            end
            if (w_sample && (r_bit != 3'd0) && (r_bit != LAST_BIT)) begin
              r_rx_shift <= {r_rx_shift[2:0], r_rxs};
            end
            if (w_frame_done) begin
              if (w_frame_ok) begin
                r_rx_move_valid <= 1'b1;
                r_rx_move_col   <= w_rx_col;
              end else begin
                r_frame_err <= 1'b1;
              end
            end
          end
          S_HALT: begin
            r_tx_data <= 1'b0;
          end
          default: begin
            r_tx_data <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_link_ctrl.sv
// Bench for move_link_ctrl: session-control vector table, directed frame sequences and a
// randomized game against a frame-level model of the move protocol.
module tb_move_link_ctrl;
  localparam int BC   = 4;
  localparam int TMO  = 100;
  localparam int CMAX = 6;

  logic       clk = 1'b0;
  logic       rst, link_up, first_player, move_valid, rx_data;
  logic [2:0] move_col;
  logic       move_ready, tx_data, rx_move_valid, my_turn, frame_err, timeout_err;
  logic [2:0] rx_move_col;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_col = 3'd0;
  logic       turn_m;

  move_link_ctrl #(.BIT_CYCLES(BC), .TIMEOUT_CYCLES(TMO), .COL_MAX(CMAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up), .i_first_player(first_player),
    .i_move_valid(move_valid), .i_move_col(move_col), .o_move_ready(move_ready),
    .o_tx_data(tx_data), .i_rx_data(rx_data), .o_rx_move_valid(rx_move_valid),
    .o_rx_move_col(rx_move_col), .o_my_turn(my_turn), .o_frame_err(frame_err),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       link;
    logic       fp;
    logic       mv;
    logic [2:0] col;
    logic       ready;
    logic       turn;
    logic       tx;
  } vec_t;
  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Wire format of a move: start, col[2:0], even parity over col, stop.
  function automatic logic [5:0] frame_of(input logic [2:0] c);
    int ones;
    ones = int'(c[2]) + int'(c[1]) + int'(c[0]);
    return {1'b1, c, 1'(ones % 2), 1'b0};
  endfunction

  function automatic bit frame_good(input logic [5:0] f);
    int ones;
    ones = int'(f[4]) + int'(f[3]) + int'(f[2]);
    return (int'(f[1]) == ones % 2) && (f[0] == 1'b0) && (int'(f[4:2]) <= CMAX);
  endfunction

  task automatic connect(input logic fp);
    link_up = 1'b0;
    tick();
    tick();
    first_player = fp;
    tick();
    chk("offline_turn", my_turn, fp);
    chk("offline_ready", move_ready, 0);
    link_up = 1'b1;
    tick();
    chk("session_turn", my_turn, fp);
    chk("session_ready", move_ready, fp);
    chk("session_tmo", timeout_err, 0);
  endtask

  task automatic local_move(input logic [2:0] c);
    logic [5:0] f;
    f = frame_of(c);
    chk("move_ready", move_ready, 1);
    move_valid = 1'b1;
    move_col   = c;
    tick();
    move_col = 3'd2;
    for (int i = 0; i < 6 * BC; i++) begin
      chk("tx_bit", tx_data, f[5 - i / BC]);
      chk("tx_turn", my_turn, 1);
      chk("tx_ready", move_ready, 0);
      tick();
    end
    move_valid = 1'b0;
    chk("tx_idle", tx_data, 0);
    chk("tx_done_turn", my_turn, 0);
  endtask

  task automatic illegal_move();
    move_valid = 1'b1;
    move_col   = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("illegal_ready", move_ready, 1);
      chk("illegal_tx", tx_data, 0);
    end
    move_valid = 1'b0;
  endtask

  task automatic remote_frame(input logic [5:0] f);
    int  v_at, e_at, nv, ne;
    bit  good;
    good = frame_good(f);
    v_at = -1; e_at = -1; nv = 0; ne = 0;
    for (int c = 0; c < 6 * BC + 8; c++) begin
      rx_data = (c < 6 * BC) ? f[5 - c / BC] : 1'b0;
      tick();
      if (rx_move_valid) begin nv++; v_at = c + 1; end
      if (frame_err) begin ne++; e_at = c + 1; end
    end
    if (good) exp_col = f[4:2];
    chk("rx_valid_count", nv, good ? 1 : 0);
    chk("rx_err_count", ne, good ? 0 : 1);
    // Pin to pulse: 2 sync stages, stop-bit mid-sample, 1 output register.
    chk("rx_pulse_cycle", good ? v_at : e_at, 2 + 5 * BC + BC / 2 + 1);
    chk("rx_col", rx_move_col, exp_col);
    chk("rx_turn", my_turn, good ? 1 : 0);
  endtask

  task automatic glitch();
    int np;
    np = 0;
    rx_data = 1'b1;
    tick();
    rx_data = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      np += int'(rx_move_valid) + int'(frame_err);
    end
    chk("glitch_pulses", np, 0);
    chk("glitch_turn", my_turn, 0);
    chk("glitch_col", rx_move_col, exp_col);
  endtask

  task automatic timeout_check();
    int at;
    at = -1;
    for (int c = 1; c <= TMO + 10; c++) begin
      tick();
      if (timeout_err && at < 0) at = c;
    end
    chk("timeout_cycle", at, TMO + 1);
    chk("halt_turn", my_turn, 0);
    chk("halt_tx", tx_data, 0);
    chk("halt_ready", move_ready, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] f;
    int         np;
    // rst, link, fp, mv, col | ready, turn, tx
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; link_up = 1'b0; first_player = 1'b1;
    move_valid = 1'b0; move_col = 3'd0; rx_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; link_up = tbl[i].link; first_player = tbl[i].fp;
      move_valid = tbl[i].mv; move_col = tbl[i].col;
      tick();
      chk("tbl_ready", move_ready, tbl[i].ready);
      chk("tbl_turn", my_turn, tbl[i].turn);
      chk("tbl_tx", tx_data, tbl[i].tx);
      chk("tbl_rxv", rx_move_valid, 0);
      chk("tbl_ferr", frame_err, 0);
      chk("tbl_tmo", timeout_err, 0);
      chk("tbl_rxcol", rx_move_col, 0);
    end
    rst = 1'b0;
    move_valid = 1'b0;

    connect(1'b1);
    local_move(3'd5);
    remote_frame(6'b101100);
    illegal_move();
    local_move(3'd6);
    remote_frame(6'b101110);
    glitch();
    remote_frame(frame_of(3'd2));
    local_move(3'd0);
    timeout_check();
    link_up = 1'b0;
    tick();
    chk("offline_tmo_sticky", timeout_err, 1);
    connect(1'b0);

    // Link loss in the middle of a received frame.
    f = frame_of(3'd4);
    for (int c = 0; c < 10; c++) begin
      rx_data = f[5 - c / BC];
      tick();
    end
    link_up = 1'b0;
    tick();
    chk("droprx_ready", move_ready, 0);
    chk("droprx_turn", my_turn, 0);
    chk("droprx_tx", tx_data, 0);
    np = int'(rx_move_valid) + int'(frame_err);
    for (int c = 11; c < 6 * BC + 8; c++) begin
      rx_data = (c < 6 * BC) ? f[5 - c / BC] : 1'b0;
      tick();
      np += int'(rx_move_valid) + int'(frame_err);
    end
    chk("droprx_pulses", np, 0);
    chk("droprx_col", rx_move_col, exp_col);

    // Link loss in the middle of a transmitted frame.
    connect(1'b1);
    move_valid = 1'b1; move_col = 3'd1;
    tick();
    move_valid = 1'b0;
    tick();
    chk("droptx_pre_tx", tx_data, 1);
    link_up = 1'b0;
    tick();
    chk("droptx_tx", tx_data, 0);
    chk("droptx_ready", move_ready, 0);
    chk("droptx_turn", my_turn, 1);
    np = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      np += int'(tx_data) + int'(rx_move_valid) + int'(frame_err);
    end
    chk("droptx_quiet", np, 0);

    // Reset in the middle of a transmitted frame.
    connect(1'b1);
    move_valid = 1'b1; move_col = 3'd5;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    chk("prerst_tx", tx_data, 1);
    first_player = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_col = 3'd0;
    chk("rst_tx", tx_data, 0);
    chk("rst_ready", move_ready, 0);
    chk("rst_turn", my_turn, 0);
    chk("rst_rxv", rx_move_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_rxcol", rx_move_col, 0);

    // Randomized game against the frame-level model.
    connect(1'b1);
    turn_m = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (turn_m) begin
        move_col = 3'($urandom_range(0, 7));
        if (int'(move_col) > CMAX) begin
          illegal_move();
        end else begin
          local_move(move_col);
          turn_m = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        glitch();
      end else begin
        f = {1'b1, 5'($urandom_range(0, 31))};
        remote_frame(f);
        turn_m = frame_good(f);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/move_link_ctrl.md
# move_link_ctrl

Sequences move exchange between the two Connect-4 boards over a single-wire serial data pair, on top of the send/receive link-presence handshake. Owns turn ownership, serializes the local move, deserializes and checks the remote move, and detects a silent opponent. Sits between the game logic and the link-handshake block: drives that block's `turn` input and consumes its `restart` output, inverted, as `link_up`.

## Interface
- `BIT_CYCLES`, 16: clock cycles per serial bit; even, >= 4.
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles spent in REMOTE_TURN before `timeout_err` is raised.
- `COL_MAX`, 6: highest legal column index.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `link_up`  in  1  link established; 0 means the link is down or restarting.
- `first_player`  in  1  sampled on the cycle `link_up` is first seen high; 1 means the local board moves first.
- `move_valid`  in  1  the local game logic offers a move.
- `move_col`  in  3  offered column.
- `move_ready`  out  1  move accepted when `move_valid` and `move_ready` are both high and `move_col` <= COL_MAX.
- `tx_data`  out  1  serial move line to the remote board; idles at 0.
- `rx_data`  in  1  serial move line from the remote board; asynchronous.
- `rx_move_valid`  out  1  one-cycle pulse: a remote move was received.
- `rx_move_col`  out  3  received column; held until the next valid move.
- `my_turn`  out  1  local board owns the turn; wired to the link block's `turn`.
- `frame_err`  out  1  one-cycle pulse: a received frame was rejected.
- `timeout_err`  out  1  sticky: the remote board went silent.

## Operation
- Frame is 6 bits, each held for BIT_CYCLES cycles, in this order: start=1, col[2], col[1], col[0], parity=^col, stop=0.
- `rx_data` passes through a 2-FF synchronizer (`rxs`). Edge detection and sampling use `rxs` only.
- States:
  - OFFLINE: entered on reset.
  - LOCAL_TURN.
  - TX.
  - REMOTE_TURN.
  - RX.
  - HALT.
- OFFLINE:
  - `my_turn` = `first_player`.
  - When `link_up` is 1, go to LOCAL_TURN if `first_player` is 1, else go to REMOTE_TURN.
  - `timeout_err` clears on that transition.
- LOCAL_TURN:
  - `move_ready` = 1.
  - An offered `move_col` > COL_MAX is ignored; `move_ready` stays high.
  - On a legal accept, latch the column and go to TX.
- TX:
  - Shift out the frame.
  - After 6*BIT_CYCLES cycles, go to REMOTE_TURN.
  - `move_valid` is ignored during TX.
- REMOTE_TURN:
  - The timeout counter is cleared on entry and counts every cycle.
  - A 0->1 edge on `rxs` goes to RX. The edge cycle is sample-count 0.
  - When the counter reaches TIMEOUT_CYCLES, set `timeout_err` and go to HALT.
- RX:
  - Sample `rxs` at counts k*BIT_CYCLES + BIT_CYCLES/2, for k = 0..5.
  - k=0 sample is 0 (false start): return to REMOTE_TURN with no error and a fresh timeout.
  - At the k=5 sample, accept the frame only if parity matches, stop = 0, and col <= COL_MAX.
  - Accept: `rx_move_col` updates, `rx_move_valid` pulses, go to LOCAL_TURN.
  - Reject: `frame_err` pulses, return to REMOTE_TURN.
- HALT:
  - `tx_data` = 0, `my_turn` = 0.
  - Leave to OFFLINE only when `link_up` is 0.
- `link_up` = 0 in any state other than OFFLINE: next state is OFFLINE, `tx_data` goes to 0, and any partial frame is discarded. This takes priority over all other transitions.
- `my_turn` = 1 in LOCAL_TURN and TX; 0 in REMOTE_TURN, RX and HALT.

## Timing
- Reset values:
  - state = OFFLINE.
  - `tx_data` = 0, `move_ready` = 0, `rx_move_valid` = 0, `rx_move_col` = 0.
  - `frame_err` = 0, `timeout_err` = 0.
  - `my_turn` = `first_player`.
- All outputs are registered except `my_turn` and `move_ready`, which decode the state.
- Start bit appears on `tx_data` the cycle after acceptance. The stop bit ends 6*BIT_CYCLES cycles later, on the same cycle the state becomes REMOTE_TURN.
- RX latency: `rx_move_valid` and `frame_err` assert the cycle after the k=5 sample, in the same cycle the state reaches LOCAL_TURN or REMOTE_TURN. Synchronizer delay from the pin is 2 cycles.
- Bit counter is 3 bits. Cycle counter is $clog2(BIT_CYCLES). Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and does not wrap.
- Simultaneous timeout and `rxs` edge in the same cycle: the edge wins and the state goes to RX.

## Test plan
(BIT_CYCLES=4, TIMEOUT_CYCLES=100)
- Reset with `first_player`=1, then `link_up`=1 -> LOCAL_TURN, `move_ready`=1, `my_turn`=1. Offer `move_col`=5 -> `tx_data` is 1,1,0,1,0,0, each bit 4 cycles, then `my_turn`=0.
- In REMOTE_TURN, drive `rx_data` frame 1,0,1,1,0,0 -> `rx_move_valid` pulses once, `rx_move_col`=3, `my_turn`=1.
- Frame 1,0,1,1,1,0 (bad parity) -> `frame_err` pulses, no `rx_move_valid`, state stays REMOTE_TURN. A 1-cycle glitch on `rx_data` -> no error, no move.
- Offer `move_col`=7 -> ignored, `move_ready` stays 1, `tx_data` stays 0. Offer 6 -> frame 1,1,1,0,0,0.
- No remote frame for 100 cycles -> `timeout_err`=1, HALT. `link_up` 0 then 1 -> `timeout_err`=0, new session starts.
- Drop `link_up` mid-TX and separately mid-RX -> next cycle OFFLINE, `tx_data`=0, no pulses. Assert `rst` mid-frame -> all reset values on the next edge.
